// File: rtl/jam_cost_server_if.sv
// Bus bundle between the JAM engine (master) and the cost-table server (slave).
// Carries the load stream, the W/J cost lookup, the result hand-off and the
// grading/status outputs.
interface jam_cost_server_if #(
  parameter int unsigned CYC_W = 19
);
  logic             LoadValid;
  logic [6:0]       LoadData;
  logic             LoadReady;
  logic [2:0]       W;
  logic [2:0]       J;
  logic [6:0]       Cost;
  logic             Valid;
  logic [9:0]       MinCost;
  logic [3:0]       MatchCount;
  logic [9:0]       ExpMinCost;
  logic [3:0]       ExpMatchCount;
  logic             Restart;
  logic             Done;
  logic             Pass;
  logic             Timeout;
  logic [CYC_W-1:0] CycleCount;

  modport master (
    output LoadValid, LoadData, W, J, Valid, MinCost, MatchCount,
           ExpMinCost, ExpMatchCount, Restart,
    input  LoadReady, Cost, Done, Pass, Timeout, CycleCount
  );

  modport slave (
    input  LoadValid, LoadData, W, J, Valid, MinCost, MatchCount,
           ExpMinCost, ExpMatchCount, Restart,
    output LoadReady, Cost, Done, Pass, Timeout, CycleCount
  );
endinterface

// File: rtl/jam_cost_server.sv
// Cost-table responder for the JAM engine: streams in an 8x8 cost matrix,
// serves combinational W/J lookups, then grades the engine's result against
// the expected values while watching a serve-phase cycle budget.
module jam_cost_server #(
  parameter int unsigned MAX_CYCLES = 430000,
  parameter int unsigned CYC_W      = 19
) (
  input logic              CLK,
  input logic              RST_N,
  jam_cost_server_if.slave bus
);
  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SERVE,
    ST_DONE
  } state_e;

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);

  state_e           state_q,   state_d;
  logic [5:0]       addr_q,    addr_d;
  logic [CYC_W-1:0] cyc_q,     cyc_d;
  logic             done_q,    done_d;
  logic             pass_q,    pass_d;
  logic             timeout_q, timeout_d;
  logic [6:0]       table_q [64];
  logic [6:0]       table_d [64];

  // Next-state, table write and grading decisions; Restart overrides everything.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cyc_d     = cyc_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    table_d   = table_q;
    if (bus.Restart) begin
      state_d   = ST_LOAD;
      addr_d    = '0;
      cyc_d     = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.LoadValid) begin
            table_d[addr_q] = bus.LoadData;
            addr_d          = addr_q + 6'd1;
            if (addr_q == 6'd63) begin
              state_d = ST_SERVE;
            end
          end
        end
        ST_SERVE: begin
          // Count includes the completing edge so the frozen value equals
          // the number of serve cycles spent.
          cyc_d = cyc_q + 1'b1;
          if (bus.Valid) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            pass_d    = (bus.MinCost == bus.ExpMinCost) &&
                        (bus.MatchCount == bus.ExpMatchCount);
            timeout_d = 1'b0;
          end else if (cyc_q == LAST_CYC) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, status and table registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_LOAD;
      addr_q    <= '0;
      cyc_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      for (int unsigned i = 0; i < 64; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cyc_q     <= cyc_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      table_q   <= table_d;
    end
  end

  // Lookup is unregistered: the engine moves W/J on the falling edge and
  // accumulates Cost on the following rising edge.
  assign bus.Cost       = (state_q == ST_LOAD) ? '0 : table_q[{bus.W, bus.J}];
  assign bus.LoadReady  = (state_q == ST_LOAD);
  assign bus.Done       = done_q;
  assign bus.Pass       = pass_q;
  assign bus.Timeout    = timeout_q;
  assign bus.CycleCount = cyc_q;
endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: directed scenarios with literal
// expectations plus randomized episodes checked every cycle against a
// behavioural model of the cost server.
module tb_jam_cost_server;
  localparam int unsigned MAX   = 16;
  localparam int unsigned CYC_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;
  bit   chk_en = 1'b0;

  jam_cost_server_if #(.CYC_W(CYC_W)) bus ();

  jam_cost_server #(.MAX_CYCLES(MAX), .CYC_W(CYC_W)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: entries accepted so far, serve cycles spent, verdict.
  int         m_loaded;
  int         m_cyc;
  bit         m_done, m_pass, m_to;
  logic [6:0] m_tab [64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loaded <= 0; m_cyc <= 0; m_done <= 0; m_pass <= 0; m_to <= 0;
      for (int i = 0; i < 64; i++) m_tab[i] <= '0;
    end else if (bus.Restart) begin
      m_loaded <= 0; m_cyc <= 0; m_done <= 0; m_pass <= 0; m_to <= 0;
    end else if (m_loaded < 64) begin
      if (bus.LoadValid) begin
        m_tab[m_loaded] <= bus.LoadData;
        m_loaded        <= m_loaded + 1;
      end
    end else if (!m_done) begin
      m_cyc <= m_cyc + 1;
      if (bus.Valid) begin
        m_done <= 1;
        m_pass <= (bus.MinCost == bus.ExpMinCost) && (bus.MatchCount == bus.ExpMatchCount);
      end else if (m_cyc + 1 == MAX) begin
        m_done <= 1;
        m_to   <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready",   32'(bus.LoadReady),  32'(m_loaded < 64));
      chk("m_cost",    32'(bus.Cost),       (m_loaded < 64) ? 32'd0 : 32'(m_tab[{bus.W, bus.J}]));
      chk("m_done",    32'(bus.Done),       32'(m_done));
      chk("m_pass",    32'(bus.Pass),       32'(m_pass));
      chk("m_timeout", 32'(bus.Timeout),    32'(m_to));
      chk("m_cycles",  32'(bus.CycleCount), 32'(m_cyc));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_restart();
    bus.Restart   = 1'b1;
    bus.LoadValid = 1'b1;
    bus.LoadData  = 7'($urandom);
    step();
    bus.Restart   = 1'b0;
    bus.LoadValid = 1'b0;
  endtask

  // mode 0: table[i]=i with idle gaps at 10 and 40; 1: 63-i; 2: random with random gaps
  task automatic load_all(input int mode);
    for (int i = 0; i < 64; i++) begin
      if ((mode == 0 && (i == 10 || i == 40)) || (mode == 2 && $urandom_range(0, 3) == 0)) begin
        bus.LoadValid = 1'b0;
        bus.LoadData  = 7'($urandom);
        step();
      end
      bus.LoadValid = 1'b1;
      bus.W = 3'($urandom); bus.J = 3'($urandom);
      case (mode)
        0:       bus.LoadData = 7'(i);
        1:       bus.LoadData = 7'(63 - i);
        default: bus.LoadData = 7'($urandom);
      endcase
      step();
    end
    bus.LoadValid = 1'b0;
  endtask

  task automatic set_exp();
    bus.ExpMinCost    = 10'($urandom);
    bus.ExpMatchCount = 4'($urandom);
  endtask

  task automatic episode();
    int n;
    do_restart();
    set_exp();
    load_all(2);
    n = $urandom_range(1, 20);
    for (int k = 0; k < n; k++) begin
      bus.W = 3'($urandom); bus.J = 3'($urandom);
      bus.LoadValid = 1'($urandom); bus.LoadData = 7'($urandom);
      bus.Valid = (k == n - 1) && ($urandom_range(0, 3) != 0);
      bus.MinCost    = $urandom_range(0, 1) ? bus.ExpMinCost : 10'($urandom);
      bus.MatchCount = $urandom_range(0, 1) ? bus.ExpMatchCount : 4'($urandom);
      step();
    end
    bus.Valid = 1'b0; bus.LoadValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.W = 3'($urandom); bus.J = 3'($urandom);
      bus.Valid = 1'($urandom);
      step();
    end
    bus.Valid = 1'b0;
  endtask

  initial begin
    bus.LoadValid = 0; bus.LoadData = 0; bus.W = 0; bus.J = 0; bus.Valid = 0;
    bus.MinCost = 0; bus.MatchCount = 0; bus.ExpMinCost = 0; bus.ExpMatchCount = 0;
    bus.Restart = 0;
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.LoadReady), 32'd1);
    chk("rst_cost",  32'(bus.Cost), 32'd0);
    chk("rst_done",  32'(bus.Done), 32'd0);
    chk("rst_cycles", 32'(bus.CycleCount), 32'd0);

    // Identity table with gaps, lookups, LoadValid ignored in SERVE, pass grading
    bus.ExpMinCost = 10'd200; bus.ExpMatchCount = 4'd3;
    load_all(0);
    chk("ready_after_load", 32'(bus.LoadReady), 32'd0);
    bus.W = 3'd5; bus.J = 3'd3; #1;
    chk("cost_5_3", 32'(bus.Cost), 32'd43);
    bus.W = 3'd7; bus.J = 3'd7; #1;
    chk("cost_7_7", 32'(bus.Cost), 32'd63);
    bus.W = 3'd0; bus.J = 3'd0;
    bus.LoadValid = 1'b1; bus.LoadData = 7'd127;
    step();
    bus.LoadValid = 1'b0; #1;
    chk("cost_no_write", 32'(bus.Cost), 32'd0);
    bus.Valid = 1'b1; bus.MinCost = 10'd200; bus.MatchCount = 4'd3;
    step();
    bus.Valid = 1'b0; #1;
    chk("pass_done", 32'(bus.Done), 32'd1);
    chk("pass_pass", 32'(bus.Pass), 32'd1);
    chk("pass_timeout", 32'(bus.Timeout), 32'd0);
    chk("pass_cycles", 32'(bus.CycleCount), 32'd2);

    // Restart from DONE clears flags
    do_restart(); #1;
    chk("rs_ready", 32'(bus.LoadReady), 32'd1);
    chk("rs_done", 32'(bus.Done), 32'd0);
    chk("rs_pass", 32'(bus.Pass), 32'd0);
    chk("rs_cycles", 32'(bus.CycleCount), 32'd0);
    chk("rs_cost", 32'(bus.Cost), 32'd0);

    // MatchCount mismatch -> fail verdict
    load_all(2);
    bus.Valid = 1'b1; bus.MinCost = 10'd200; bus.MatchCount = 4'd4;
    step();
    bus.Valid = 1'b0; #1;
    chk("mm_done", 32'(bus.Done), 32'd1);
    chk("mm_pass", 32'(bus.Pass), 32'd0);

    // Timeout after MAX serve cycles; later Valid ignored
    do_restart();
    load_all(2);
    for (int k = 0; k < 16; k++) begin
      bus.W = 3'($urandom); bus.J = 3'($urandom);
      step();
    end
    #1;
    chk("to_done", 32'(bus.Done), 32'd1);
    chk("to_timeout", 32'(bus.Timeout), 32'd1);
    chk("to_pass", 32'(bus.Pass), 32'd0);
    chk("to_cycles", 32'(bus.CycleCount), 32'd16);
    bus.Valid = 1'b1; bus.MinCost = bus.ExpMinCost; bus.MatchCount = bus.ExpMatchCount;
    step(); step();
    bus.Valid = 1'b0; #1;
    chk("to_frozen", 32'(bus.CycleCount), 32'd16);
    chk("to_hold", 32'(bus.Timeout), 32'd1);

    // Valid on the budget edge wins
    do_restart();
    load_all(2);
    for (int k = 0; k < 15; k++) step();
    bus.Valid = 1'b1; bus.MinCost = bus.ExpMinCost; bus.MatchCount = bus.ExpMatchCount;
    step();
    bus.Valid = 1'b0; #1;
    chk("edge_done", 32'(bus.Done), 32'd1);
    chk("edge_timeout", 32'(bus.Timeout), 32'd0);
    chk("edge_pass", 32'(bus.Pass), 32'd1);
    chk("edge_cycles", 32'(bus.CycleCount), 32'd16);

    // Reset mid-load at addr 30, then a fresh load starts at address 0
    do_restart();
    for (int i = 0; i < 30; i++) begin
      bus.LoadValid = 1'b1; bus.LoadData = 7'($urandom);
      step();
    end
    bus.LoadValid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    load_all(1);
    bus.W = 3'd0; bus.J = 3'd0; #1;
    chk("rl_cost_0", 32'(bus.Cost), 32'd63);
    bus.W = 3'd7; bus.J = 3'd7; #1;
    chk("rl_cost_63", 32'(bus.Cost), 32'd0);

    // Randomized episodes
    for (int e = 0; e < 30; e++) episode();

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
